// File: rtl/adc_sar_ctrl.sv
// adc_sar_ctrl: successive-approximation controller for a 4-channel ADC/DAC macro.
// It scans the enabled channels one at a time. Each channel is sampled, then
// resolved one bit at a time (MSB first) through its DAC and comparator. Each
// result is published on a single-cycle conv_done strobe and kept in ch_data*.
//
// Optional build macro: ADC_RESULT_SYNC_EN
//   When defined, result_in passes through a 2-flop synchronizer per bit before
//   it is evaluated, and each bit step lasts SETTLE_CYC+2 cycles.
//
// Ports:
//   mclk, reset          clock and synchronous active-high reset
//   cfg_start/cfg_abort  single-cycle scan start / abort pulses
//   cfg_cont             1 = rescan continuously
//   cfg_ch_mask[3:0]     channel enables, latched at start / rescan
//   result_in[3:0]       comparator outputs (1 = DAC code <= analog input)
//   sample_out[3:0]      sample triggers
//   dac_din0..3[7:0]     DAC trial codes
//   busy                 scan in progress
//   conv_done/conv_ch/conv_data  completion strobe with channel and result
//   ch_data0..3[7:0]     last result per channel
//   ch_valid[3:0]        channel result written since reset
module adc_sar_ctrl #(
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       cfg_start,
  input  logic       cfg_abort,
  input  logic       cfg_cont,
  input  logic [3:0] cfg_ch_mask,
  input  logic [3:0] result_in,
  output logic [3:0] sample_out,
  output logic [7:0] dac_din0,
  output logic [7:0] dac_din1,
  output logic [7:0] dac_din2,
  output logic [7:0] dac_din3,
  output logic       busy,
  output logic       conv_done,
  output logic [1:0] conv_ch,
  output logic [7:0] conv_data,
  output logic [7:0] ch_data0,
  output logic [7:0] ch_data1,
  output logic [7:0] ch_data2,
  output logic [7:0] ch_data3,
  output logic [3:0] ch_valid
);

`ifdef ADC_RESULT_SYNC_EN
  localparam int STEP_CYC = SETTLE_CYC + 2;
`else
  localparam int STEP_CYC = SETTLE_CYC;
`endif
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYC - 1);
  localparam logic [15:0] STEP_LAST   = 16'(STEP_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_BIT, ST_DONE} state_t;

  state_t      state, state_n;
  logic [1:0]  ch, ch_n;
  logic [3:0]  scan_mask, scan_mask_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  code, code_n;
  logic        commit;
  logic        res_bit;
  logic [3:0]  above;
  logic [7:0]  trial;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (m[i] && !found) begin
        lowest = 2'(i);
        found  = 1'b1;
      end
    end
  endfunction

`ifdef ADC_RESULT_SYNC_EN
  logic [3:0] sync1, sync2;
  always_ff @(posedge mclk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= result_in;
      sync2 <= sync1;
    end
  end
  assign res_bit = sync2[ch];
`else
  assign res_bit = result_in[ch];
`endif

  // Channels in the latched mask strictly above the current one.
  assign above = scan_mask & ~((4'b0010 << ch) - 4'b0001);
  assign trial = code | (8'b0000_0001 << idx);

  always_ff @(posedge mclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ch        <= '0;
      scan_mask <= '0;
      cnt       <= '0;
      idx       <= '0;
      code      <= '0;
      ch_data0  <= '0;
      ch_data1  <= '0;
      ch_data2  <= '0;
      ch_data3  <= '0;
      ch_valid  <= '0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      scan_mask <= scan_mask_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      code      <= code_n;
      if (commit) begin
        ch_valid[ch] <= 1'b1;
        case (ch)
          2'd0:    ch_data0 <= code;
          2'd1:    ch_data1 <= code;
          2'd2:    ch_data2 <= code;
          default: ch_data3 <= code;
        endcase
      end
    end
  end

  always_comb begin
    state_n     = state;
    ch_n        = ch;
    scan_mask_n = scan_mask;
    cnt_n       = cnt;
    idx_n       = idx;
    code_n      = code;
    commit      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start && cfg_ch_mask != '0) begin
          scan_mask_n = cfg_ch_mask;
          ch_n        = lowest(cfg_ch_mask);
          cnt_n       = '0;
          state_n     = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (cnt == SAMPLE_LAST) begin
          cnt_n   = '0;
          code_n  = '0;
          idx_n   = 3'd7;
          state_n = ST_BIT;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_BIT: begin
        if (cnt == STEP_LAST) begin
          cnt_n = '0;
          if (res_bit) code_n = trial;
          if (idx == 3'd0) state_n = ST_DONE;
          else idx_n = idx - 3'd1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        commit = 1'b1;
        cnt_n  = '0;
        if (above != '0) begin
          ch_n    = lowest(above);
          state_n = ST_SAMPLE;
        end else if (cfg_cont) begin
          scan_mask_n = cfg_ch_mask;
          ch_n        = lowest(cfg_ch_mask);
          state_n     = (cfg_ch_mask != '0) ? ST_SAMPLE : ST_IDLE;
        end else begin
          state_n = ST_IDLE;
        end
      end
    endcase
    // Abort overrides everything, including the commit of a same-cycle DONE.
    if (cfg_abort && state != ST_IDLE) begin
      state_n = ST_IDLE;
      commit  = 1'b0;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign conv_done  = (state == ST_DONE) && !cfg_abort;
  assign conv_ch    = conv_done ? ch : '0;
  assign conv_data  = conv_done ? code : '0;
  assign sample_out = (state == ST_SAMPLE) ? (4'b0001 << ch) : '0;
  assign dac_din0   = (state == ST_BIT && ch == 2'd0) ? trial : '0;
  assign dac_din1   = (state == ST_BIT && ch == 2'd1) ? trial : '0;
  assign dac_din2   = (state == ST_BIT && ch == 2'd2) ? trial : '0;
  assign dac_din3   = (state == ST_BIT && ch == 2'd3) ? trial : '0;

endmodule

// File: tb/tb_adc_sar_ctrl.sv
module tb_adc_sar_ctrl;

`ifdef ADC_RESULT_SYNC_EN
  localparam int STEP = 2 + 2;
`else
  localparam int STEP = 2;
`endif
  localparam int LAT = 4 + 8 * STEP + 1;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_abort = 1'b0;
  logic       cfg_cont = 1'b0;
  logic [3:0] cfg_ch_mask = '0;
  logic [3:0] result_in;
  logic [3:0] sample_out;
  logic [7:0] dac_din0, dac_din1, dac_din2, dac_din3;
  logic       busy, conv_done;
  logic [1:0] conv_ch;
  logic [7:0] conv_data;
  logic [7:0] ch_data0, ch_data1, ch_data2, ch_data3;
  logic [3:0] ch_valid;

  logic [7:0] vin [4];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int viol = 0;

  typedef struct {
    int         c;
    logic [1:0] ch;
    logic [7:0] d;
  } ev_t;
  ev_t        conv_q[$];
  logic [7:0] trial_q[$];
  logic [7:0] last1 = '0;

  adc_sar_ctrl #(.SAMPLE_CYC(4), .SETTLE_CYC(2)) dut (
    .mclk(mclk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_cont(cfg_cont), .cfg_ch_mask(cfg_ch_mask), .result_in(result_in),
    .sample_out(sample_out), .dac_din0(dac_din0), .dac_din1(dac_din1),
    .dac_din2(dac_din2), .dac_din3(dac_din3), .busy(busy), .conv_done(conv_done),
    .conv_ch(conv_ch), .conv_data(conv_data), .ch_data0(ch_data0),
    .ch_data1(ch_data1), .ch_data2(ch_data2), .ch_data3(ch_data3),
    .ch_valid(ch_valid)
  );

  // Analog macro model: comparator high when the DAC code does not exceed vin.
  assign result_in = {dac_din3 <= vin[3], dac_din2 <= vin[2],
                      dac_din1 <= vin[1], dac_din0 <= vin[0]};

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  function automatic int nz(input logic [7:0] a, b, c, d);
    return int'(a != 0) + int'(b != 0) + int'(c != 0) + int'(d != 0);
  endfunction

  always @(negedge mclk) begin
    if (conv_done) conv_q.push_back('{cyc, conv_ch, conv_data});
    if (dac_din1 != last1) begin
      if (dac_din1 != 8'h00) trial_q.push_back(dac_din1);
      last1 = dac_din1;
    end
    if ($countones(sample_out) > 1 || nz(dac_din0, dac_din1, dac_din2, dac_din3) > 1 ||
        (sample_out != 0 && nz(dac_din0, dac_din1, dac_din2, dac_din3) != 0) ||
        (!busy && (sample_out != 0 || nz(dac_din0, dac_din1, dac_din2, dac_din3) != 0)))
      viol++;
  end

  task automatic pulse_start(input logic [3:0] m);
    @(negedge mclk);
    cfg_ch_mask = m;
    cfg_start   = 1'b1;
    @(negedge mclk);
    cfg_start   = 1'b0;
    start_cyc   = cyc;
  endtask

  task automatic wait_events(input int n, input int limit);
    int g = 0;
    while (conv_q.size() < n && g < limit) begin
      @(posedge mclk);
      g++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    tests++;
    if ({busy, conv_done, sample_out, ch_valid} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got busy=%b done=%b sample=%b valid=%b expected all 0",
               busy, conv_done, sample_out, ch_valid);
    end
    tests++;
    if ({dac_din0, dac_din1, dac_din2, dac_din3, ch_data0, ch_data1, ch_data2, ch_data3,
         conv_ch, conv_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: got dac=%h %h %h %h ch_data=%h %h %h %h expected 0",
               dac_din0, dac_din1, dac_din2, dac_din3, ch_data0, ch_data1, ch_data2, ch_data3);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    conv_q.delete();
    vin[0] = 8'h11;
    cfg_cont = 1'b0;
    pulse_start(4'b0001);
    tests++;
    if (busy !== 1'b1 || sample_out !== 4'b0001) begin
      fails++;
      $display("FAIL single_start: got busy=%b sample=%b expected 1 0001", busy, sample_out);
    end
    repeat (3) @(negedge mclk);
    @(negedge mclk);
    tests++;
    if (dac_din0 !== 8'h80) begin
      fails++;
      $display("FAIL single_first_trial: got %h expected 80", dac_din0);
    end
    wait_events(1, 200);
    @(negedge mclk);
    tests++;
    if (conv_q.size() != 1) begin
      fails++;
      $display("FAIL single_count: got %0d expected 1", conv_q.size());
    end else begin
      tests++;
      if (conv_q[0].c - start_cyc + 1 != LAT || conv_q[0].ch !== 2'd0 || conv_q[0].d !== 8'h11) begin
        fails++;
        $display("FAIL single_conv: got lat=%0d ch=%0d data=%h expected lat=%0d ch=0 data=11",
                 conv_q[0].c - start_cyc + 1, conv_q[0].ch, conv_q[0].d, LAT);
      end
    end
    tests++;
    if (busy !== 1'b0 || ch_valid !== 4'b0001 || ch_data0 !== 8'h11) begin
      fails++;
      $display("FAIL single_after: got busy=%b valid=%b data0=%h expected 0 0001 11",
               busy, ch_valid, ch_data0);
    end
  endtask

  // Reference: channels resolve in ascending order of the mask, each to its vin,
  // one channel every LAT cycles with no gaps.
  task automatic run_scan(input logic [3:0] m, input string name);
    int exp_ch[$];
    for (int n = 0; n < 4; n++) if (m[n]) exp_ch.push_back(n);
    conv_q.delete();
    cfg_cont = 1'b0;
    pulse_start(m);
    wait_events(exp_ch.size(), 200 * exp_ch.size());
    @(negedge mclk);
    tests++;
    if (conv_q.size() != exp_ch.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d expected %0d", name, conv_q.size(), exp_ch.size());
    end else begin
      for (int i = 0; i < exp_ch.size(); i++) begin
        tests++;
        if (conv_q[i].c - start_cyc + 1 != (i + 1) * LAT || conv_q[i].ch !== 2'(exp_ch[i]) ||
            conv_q[i].d !== vin[exp_ch[i]]) begin
          fails++;
          $display("FAIL %s_conv%0d: got t=%0d ch=%0d data=%h expected t=%0d ch=%0d data=%h",
                   name, i, conv_q[i].c - start_cyc + 1, conv_q[i].ch, conv_q[i].d,
                   (i + 1) * LAT, exp_ch[i], vin[exp_ch[i]]);
        end
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_drop: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_full_scan();
    vin[0] = 8'h11; vin[1] = 8'h22; vin[2] = 8'h33; vin[3] = 8'h44;
    run_scan(4'b1111, "full");
    tests++;
    if ({ch_data3, ch_data2, ch_data1, ch_data0} !== 32'h44332211 || ch_valid !== 4'b1111) begin
      fails++;
      $display("FAIL full_ch_data: got %h%h%h%h valid=%b expected 44332211 1111",
               ch_data3, ch_data2, ch_data1, ch_data0, ch_valid);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] exp_seq [8];
    exp_seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    vin[0] = 8'h00; vin[1] = 8'hFF;
    trial_q.delete();
    run_scan(4'b0011, "extreme");
    tests++;
    if (trial_q.size() != 8) begin
      fails++;
      $display("FAIL trial_seq_len: got %0d expected 8", trial_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (trial_q[i] !== exp_seq[i]) begin
          fails++;
          $display("FAIL trial_seq%0d: got %h expected %h", i, trial_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      for (int n = 0; n < 4; n++) vin[n] = 8'($urandom);
      run_scan(4'($urandom_range(1, 15)), "rand");
    end
  endtask

  task automatic test_abort();
    logic [7:0] old2;
    logic [3:0] oldv;
    int         qn;
    vin[0] = 8'h5A; vin[1] = 8'h81; vin[2] = 8'h33;
    old2 = ch_data2;
    oldv = ch_valid;
    conv_q.delete();
    pulse_start(4'b0111);
    wait_events(2, 400);
    repeat (10) @(posedge mclk);
    @(negedge mclk);
    tests++;
    // Bit 4 trial: bits above it already resolved to vin's, plus the trial bit.
    if (dac_din2 !== ((vin[2] & 8'hE0) | 8'h10)) begin
      fails++;
      $display("FAIL abort_bit4_code: got %h expected %h", dac_din2, (vin[2] & 8'hE0) | 8'h10);
    end
    cfg_abort = 1'b1;
    @(negedge mclk);
    cfg_abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || sample_out !== '0 ||
        {dac_din0, dac_din1, dac_din2, dac_din3} !== '0) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b sample=%b dac2=%h expected 0 0000 00",
               busy, sample_out, dac_din2);
    end
    qn = conv_q.size();
    repeat (40) @(negedge mclk);
    tests++;
    if (qn != 2 || conv_q.size() != 2 || ch_data2 !== old2 || ch_valid !== (oldv | 4'b0011)) begin
      fails++;
      $display("FAIL abort_no_result: got convs=%0d data2=%h valid=%b expected 2 %h %b",
               conv_q.size(), ch_data2, ch_valid, old2, oldv | 4'b0011);
    end
  endtask

  task automatic test_cont();
    int exp_ch [4];
    exp_ch = '{0, 2, 0, 2};
    vin[0] = 8'($urandom); vin[2] = 8'($urandom);
    conv_q.delete();
    cfg_cont = 1'b1;
    pulse_start(4'b0101);
    repeat (30) @(negedge mclk);
    cfg_start = 1'b1;
    @(negedge mclk);
    cfg_start = 1'b0;
    wait_events(4, 400);
    @(negedge mclk);
    tests++;
    if (conv_q.size() < 4) begin
      fails++;
      $display("FAIL cont_count: got %0d expected 4", conv_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (conv_q[i].c - start_cyc + 1 != (i + 1) * LAT || conv_q[i].ch !== 2'(exp_ch[i]) ||
            conv_q[i].d !== vin[exp_ch[i]]) begin
          fails++;
          $display("FAIL cont_conv%0d: got t=%0d ch=%0d data=%h expected t=%0d ch=%0d data=%h",
                   i, conv_q[i].c - start_cyc + 1, conv_q[i].ch, conv_q[i].d,
                   (i + 1) * LAT, exp_ch[i], vin[exp_ch[i]]);
        end
      end
    end
    cfg_abort = 1'b1;
    @(negedge mclk);
    cfg_abort = 1'b0;
    cfg_cont = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL cont_abort: got busy=%b expected 0", busy);
    end
    pulse_start(4'b0000);
    repeat (2) @(negedge mclk);
    tests++;
    if (busy !== 1'b0 || sample_out !== '0) begin
      fails++;
      $display("FAIL zero_mask_start: got busy=%b sample=%b expected 0 0000", busy, sample_out);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(4'b0001);
    @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk);
    tests++;
    if ({busy, conv_done, sample_out, ch_valid, dac_din0, ch_data0, ch_data1, ch_data2,
         ch_data3} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b sample=%b valid=%b data=%h %h %h %h expected all 0",
               busy, sample_out, ch_valid, ch_data0, ch_data1, ch_data2, ch_data3);
    end
    reset = 1'b0;
    @(negedge mclk);
  endtask

  task automatic test_inactive();
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL inactive_channels: got %0d violating cycles expected 0", viol);
    end
  endtask

  initial begin
    for (int n = 0; n < 4; n++) vin[n] = 8'h00;
    test_reset();
    test_single();
    test_full_scan();
    test_extremes();
    test_random();
    test_abort();
    test_cont();
    test_reset_mid();
    test_inactive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
